// File: rtl/prog_freq_div.sv
// prog_freq_div: runtime-programmable integer clock divider (N = 2..2^W-1) with glitch-free
// divisor changes at period boundaries. Define PROG_FREQ_DIV_DUTY50_EN for 50% duty on odd N.
module prog_freq_div #(
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_val,
  input  logic         div_load,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] cur_div,
  output logic         pend,
  output logic         cfg_err
);

  localparam int MAX_DIV = (1 << W) - 1;

  if (DEF_DIV < 2 || DEF_DIV > MAX_DIV) begin : g_bad_def_div
    $error("prog_freq_div: DEF_DIV=%0d outside 2..%0d", DEF_DIV, MAX_DIV);
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pdiv_q, pdiv_d;
  logic         pend_q, pend_d;
  logic         hi_q, hi_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;

  logic         load_ok;
  logic         at_wrap;
  logic         boundary;
  logic [W-1:0] cnt_inc;

  // State register: every flop shares the synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= W'(DEF_DIV);
      pdiv_q  <= W'(DEF_DIV);
      pend_q  <= 1'b0;
      hi_q    <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. IDLE counts as a boundary, so loads there apply at once.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pdiv_d   = pdiv_q;
    pend_d   = pend_q;
    hi_d     = hi_q;
    tick_d   = 1'b0;
    cnt_inc  = cnt_q + W'(1);

    load_ok  = div_load && (div_val >= W'(2));
    err_d    = div_load && (div_val <  W'(2));
    at_wrap  = (state_q == RUN) && (cnt_q == div_q - W'(1));
    boundary = (state_q == IDLE) || at_wrap;

    if (boundary) begin
      // Same-edge load beats an older pending value; either way pend clears.
      if (load_ok) begin
        div_d = div_val;
      end else if (pend_q) begin
        div_d = pdiv_q;
      end
      pend_d = 1'b0;
    end else if (load_ok) begin
      pdiv_d = div_val;
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          hi_d    = 1'b1;
          tick_d  = 1'b1;
        end else begin
          hi_d    = 1'b0;
        end
      end
      RUN: begin
        if (at_wrap) begin
          cnt_d = '0;
          if (en) begin
            hi_d   = 1'b1;
            tick_d = 1'b1;
          end else begin
            state_d = IDLE;
            hi_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          hi_d  = (cnt_inc < (div_q >> 1));
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hi_d    = 1'b0;
      end
    endcase
  end

`ifdef PROG_FREQ_DIV_DUTY50_EN
  logic hi_n_q;

  // Half-cycle delayed copy stretches the odd-N high time by half a clk period.
  always_ff @(negedge clk) begin
    if (!rst) begin
      hi_n_q <= 1'b0;
    end else begin
      hi_n_q <= hi_q;
    end
  end
`endif

  // Output logic.
  always_comb begin
`ifdef PROG_FREQ_DIV_DUTY50_EN
    clk_out = hi_q | (hi_n_q & div_q[0]);
`else
    clk_out = hi_q;
`endif
    tick    = tick_q;
    cur_div = div_q;
    pend    = pend_q;
    cfg_err = err_q;
  end

endmodule

// File: doc/prog_freq_div.md
Name: prog_freq_div

Overview:
- Runtime-programmable integer clock divider. Generalises the fixed-ratio divider (fixed div2..div7 taps) to any divisor 2..2^W-1.
- Produces a divided clock-enable-style square wave `clk_out` and a one-cycle `tick` at each output period start.
- Divisor changes are applied glitch-free at period boundaries; enable/disable is graceful (current period always completes).
- Sits between the system clock and slow peripheral timing (baud, LED, sample strobes).

Parameters:
- W, 8: divisor width in bits.
- DEF_DIV, 2: divisor active after reset. Must be 2..2^W-1; elaboration error otherwise.

Ports:
- clk  in  1  system clock; all logic on rising edge (except the optional feature).
- rst  in  1  synchronous active-low reset.
- en  in  1  run request.
- div_val  in  W  requested divisor N.
- div_load  in  1  one-cycle strobe; samples div_val.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse on the clk edge where clk_out rises.
- cur_div  out  W  divisor currently in use.
- pend  out  1  a loaded divisor is waiting for the next boundary.
- cfg_err  out  1  one-cycle pulse: div_load with div_val < 2.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State = IDLE, cnt = 0, cur_div = DEF_DIV, pend = 0.
  - clk_out, tick and cfg_err = 0. Any pending divisor is discarded.
- High time: H = floor(N/2). clk_out = 1 for cnt in 0..H-1 and 0 for cnt in H..N-1. It is registered, aligned with cnt.
- IDLE state:
  - cnt = 0, clk_out = 0.
  - When en=1 at an edge: go to RUN. Same edge sets cnt = 0, clk_out = 1 and tick = 1.
  - If a divisor is pending on that edge, it is applied first.
- RUN state:
  - cnt increments each cycle. At cnt = N-1 the next edge is a wrap.
  - If en=1 at the wrap: cnt -> 0, clk_out -> 1, tick = 1, and any pending divisor is applied (cur_div updated, pend cleared).
  - If en=0 at the wrap: go to IDLE, clk_out = 0, no tick, and any pending divisor is applied.
  - Deasserting en mid-period never shortens the period.
- Divisor load rules:
  - div_load with div_val >= 2 stores the value in the pending register and sets pend = 1.
  - Multiple loads before a boundary: last one wins.
  - Load on the same edge as a wrap or IDLE->RUN: takes effect in the period starting at that edge; pend stays 0.
  - Load while IDLE with en=0: applied immediately (cur_div updates next cycle); pend stays 0.
  - div_val in {0,1}: ignored, pending value unchanged, cfg_err = 1 for one cycle.
- Latency: from div_load to the new period is at most one full old period.
- tick is high exactly one cycle per output period and 0 in IDLE.
- Arithmetic: cnt is W bits, compared against cur_div-1. No overflow, since N <= 2^W-1.
- Reset asserted mid-period: immediate IDLE on that edge; no partial-period completion.

Optional Feature:
- Macro: PROG_FREQ_DIV_DUTY50_EN.
- Defined:
  - A falling-edge flop of clk samples the internal posedge clk_out copy. It is synchronously reset to 0 on the falling edge when rst=0.
  - For odd N, clk_out = posedge copy OR negedge copy, giving a high time of exactly N/2 clk periods (50% duty).
  - For even N the negedge copy is masked and behaviour is unchanged.
  - clk_out is then combinational from two flops.
- Not defined: odd N gives high floor(N/2) and low ceil(N/2) cycles. Pure posedge logic; clk_out driven directly by a flop.

Test Plan:
- Reset/default: rst=0 for 2 cycles, then rst=1, en=1 -> tick on first enabled edge. clk_out toggles 1,0,1,0 (N=2); cur_div=2, pend=0, cfg_err=0.
- Even/odd ratio: load 6 while IDLE, then en=1 -> clk_out 3 high / 3 low, tick every 6 cycles. Load 7 -> 3 high / 4 low, or 3.5/3.5 with PROG_FREQ_DIV_DUTY50_EN.
- Glitch-free change: running N=8, load 3 at cnt=2 -> pend=1 until the wrap. Old period completes as 8 cycles, then 3-cycle periods; pend clears at the wrap.
- Load collision: running N=5, loads 4 then 9 before the wrap -> first new period is 9. Load 0 -> cfg_err pulse, cur_div unchanged.
- Graceful stop: N=10, en=0 at cnt=3 -> output continues to cnt=9, then IDLE with clk_out=0 and no further tick. en=1 restarts with tick on the same edge.
- Reset mid-run: N=12, rst=0 at cnt=5 -> next edge gives clk_out=0, cur_div=DEF_DIV, pend=0, state IDLE.
